pipeline_control_unit: RTL and testbench
========================================

# pipeline_control_unit

Pipelined successor to the single-cycle decode controller. Decodes the MIPS-subset instruction in the IF/ID stage, registers the control bundle into the ID/EX stage, and generates stall and flush for load-use hazards, a multi-cycle multiplier and taken branches/jumps. Sits between the IF/ID register and the execute datapath of the five-stage core.

## Interface
- `ALUOP_W`, default 4: width of the ALU operation code.
- `MUL_LATENCY`, default 3: number of cycles a MUL occupies EX. Legal range 1..15.
- `Clk`  in  1  core clock, rising edge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `Instr`  in  32  instruction in IF/ID. Fields: op[31:26], rs[25:21], rt[20:16], funct[5:0].
- `InstrValid`  in  1  IF/ID holds a real instruction. When low, the instruction is treated as a bubble.
- `Redirect`  in  1  from EX: the branch/jump/JR in EX is resolved taken.
- `ExRegWrite, ExALUSrc, ExMemWrite, ExMemRead, ExBranch, ExJump, ExJumpReg, ExValid`  out  1 each  registered ID/EX controls.
- `ExALUOp`  out  ALUOP_W  registered ALU operation.
- `ExRegDst`  out  2  0=rt, 1=rd, 2=r31.
- `ExMemToReg`  out  2  0=mem, 1=ALU, 2=PC+4.
- `ExStoreType`, `ExLoadType`  out  2 each  0=word, 1=half, 2=byte.
- `ExRt`  out  5  registered rt field, used for hazard compare.
- `Stall`  out  1  combinational: hold PC and IF/ID.
- `Flush`  out  1  combinational: squash IF/ID.
- `IllegalInstr`  out  1  registered one-cycle pulse.

## Operation
- The decode is combinational and uses the same opcode set as the current controller:
  - R-type (op 0): funct 0x08 is JR. Every other funct is an R-op with RegDst=1.
  - MUL: op 0x1C.
  - Immediates: ANDI, ADDI, ORI, XORI, SLTI.
  - Loads: LW, LH, LB.
  - Stores: SW, SH, SB.
  - Branches: BEQ, BNE, BLEZ (0x06), BGTZ (0x07, corrected from the old duplicate 0x01).
  - REGIMM (0x01): rt=1 is BGEZ, rt=0 is BLTZ, any other rt is illegal.
  - Jumps: J, JAL. JAL sets MemRead=0 (corrected), RegDst=2 and MemToReg=2.
- Every unlisted opcode is illegal. An illegal instruction inserts a bubble and raises `IllegalInstr` for one cycle.
- Bubble: every Ex* output is 0, including `ExValid`.
- Load-use hazard:
  - Condition: ExValid & ExMemRead & ExRt≠0, and ExRt equals the decoded rs, or equals rt when the decoded instruction reads rt (R-type, stores, BEQ/BNE).
  - Response: `Stall`=1 for one cycle and a bubble enters ID/EX.
- MUL busy:
  - When a MUL is registered into ID/EX, a 4-bit `busy_cnt` loads MUL_LATENCY−1.
  - While busy_cnt≠0: `Stall`=1, ID/EX holds its contents, and busy_cnt decrements each cycle.
  - MUL_LATENCY=1 never stalls.
- Redirect: `Flush`=1 and `Stall`=0, and a bubble enters ID/EX.
- Priority: Redirect > MUL busy > load-use > normal decode.
- Redirect with busy_cnt≠0 cannot occur, because a redirecting instruction is never a MUL. If it does occur, Redirect wins and busy_cnt clears.
- FSM states: RUN and MULWAIT (MULWAIT is entered when busy_cnt≠0).
  - RUN→MULWAIT: a MUL is registered and MUL_LATENCY>1.
  - MULWAIT→RUN: busy_cnt reaches 1 → 0.
  - Any→RUN: Redirect.

## Timing
- Reset (`Rst_n` low, asynchronous):
  - All Ex* outputs are 0.
  - busy_cnt=0, state RUN.
  - IllegalInstr=0.
  - Stall and Flush are 0 while reset is asserted.
- Reset deassertion mid-MULWAIT returns the block to RUN. No stall is carried over.
- ID→EX latency is one cycle: a decoded instruction appears on Ex* after the next rising Clk.
- `Stall` and `Flush` are combinational from the current state, `Instr` and `Redirect`, and are valid in the same cycle.
- A load-use stall lasts exactly 1 cycle. After that cycle the bubble is in EX, so the hazard condition clears.
- A MUL produces exactly MUL_LATENCY−1 stall cycles, starting the cycle after the MUL enters EX.
- InstrValid=0 produces a bubble and never causes a stall.

## Structure
- `pipeline_ctrl_pkg` holds:
  - opcode and funct constants;
  - ALUOp code localparams;
  - RegDst, MemToReg and Load/StoreType encodings;
  - the `ctrl_bundle_t` struct.
- Sub-module `instr_decoder`: purely combinational Instr → ctrl_bundle_t, plus illegal flag and uses_rt flag.
- The top level holds the ID/EX register, busy_cnt/FSM and hazard logic.

## Test plan
- Reset mid-operation: assert Rst_n low while in MULWAIT → all outputs 0 immediately. After release, ADDI decodes normally with no stall.
- LW $t0 followed by ADD $t1,$t0,$t2 → Stall=1 for exactly 1 cycle, one bubble (ExValid=0), then ADD with ExRegDst=1.
- MUL with MUL_LATENCY=3, then ORI → Stall high for 2 cycles and ExALUOp held; ORI reaches EX on cycle 4.
- BEQ in EX with Redirect=1 while a load-use hazard is also present → Flush=1, Stall=0, bubble enters ID/EX.
- REGIMM with rt=1 → BGEZ branch bundle. REGIMM with rt=3 → bubble and IllegalInstr=1 for 1 cycle. Op 0x07 → BGTZ bundle.
- JAL → ExRegDst=2, ExMemToReg=2, ExMemRead=0, ExJump=1. LW $0 followed by a user of $0 → no stall.

Source files
------------

// File: rtl/pipeline_control_unit_pkg.sv
// Shared encodings and the ID/EX control bundle for the pipelined decode controller.
package pipeline_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_MUL    = 6'h1C;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_RTYPE = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_OR    = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_MUL   = 4'd7;

  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2} reg_dst_e;
  typedef enum logic [1:0] {WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2} mem_to_reg_e;
  typedef enum logic [1:0] {SZ_WORD = 2'd0, SZ_HALF = 2'd1, SZ_BYTE = 2'd2} mem_size_e;

  typedef struct packed {
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic        mem_read;
    logic        branch;
    logic        jump;
    logic        jump_reg;
    logic        valid;
    logic [3:0]  alu_op;
    reg_dst_e    reg_dst;
    mem_to_reg_e mem_to_reg;
    mem_size_e   store_type;
    mem_size_e   load_type;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipeline_control_unit_decoder.sv
// Combinational decode of the IF/ID instruction into a control bundle.
module instr_decoder
  import pipeline_ctrl_pkg::*;
(
  input  logic [31:0]  instr_i,
  output ctrl_bundle_t ctrl_o,
  output logic         illegal_o,
  output logic         uses_rt_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_bits;

  assign op          = instr_i[31:26];
  assign rt          = instr_i[20:16];
  assign funct       = instr_i[5:0];
  assign unused_bits = ^{instr_i[25:21], instr_i[15:6]};

  always_comb begin
    ctrl_o       = CTRL_BUBBLE;
    ctrl_o.valid = 1'b1;
    illegal_o    = 1'b0;
    uses_rt_o    = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          ctrl_o.jump_reg = 1'b1;
        end else begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.reg_dst    = DST_RD;
          ctrl_o.mem_to_reg = WB_ALU;
          ctrl_o.alu_op     = ALU_RTYPE;
          uses_rt_o         = 1'b1;
        end
      end
      // MUL is register-register like the R-ops, so it reads rt too.
      OP_MUL: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = DST_RD;
        ctrl_o.mem_to_reg = WB_ALU;
        ctrl_o.alu_op     = ALU_MUL;
        uses_rt_o         = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = WB_ALU;
        case (op)
          OP_SLTI: ctrl_o.alu_op = ALU_SLT;
          OP_ANDI: ctrl_o.alu_op = ALU_AND;
          OP_ORI:  ctrl_o.alu_op = ALU_OR;
          OP_XORI: ctrl_o.alu_op = ALU_XOR;
          default: ctrl_o.alu_op = ALU_ADD;
        endcase
      end
      OP_LW, OP_LH, OP_LB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = WB_MEM;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.load_type  = (op == OP_LW) ? SZ_WORD : (op == OP_LH) ? SZ_HALF : SZ_BYTE;
      end
      OP_SW, OP_SH, OP_SB: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.store_type = (op == OP_SW) ? SZ_WORD : (op == OP_SH) ? SZ_HALF : SZ_BYTE;
        uses_rt_o         = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
        uses_rt_o     = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ || rt == RT_BGEZ) begin
          ctrl_o.branch = 1'b1;
          ctrl_o.alu_op = ALU_SUB;
        end else begin
          ctrl_o    = CTRL_BUBBLE;
          illegal_o = 1'b1;
        end
      end
      OP_J: ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump       = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = DST_R31;
        ctrl_o.mem_to_reg = WB_PC4;
      end
      default: begin
        ctrl_o    = CTRL_BUBBLE;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// ID/EX control register with load-use, multi-cycle MUL and redirect hazard handling.
module pipeline_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [31:0]        Instr,
  input  logic               InstrValid,
  input  logic               Redirect,
  output logic               ExRegWrite,
  output logic               ExALUSrc,
  output logic               ExMemWrite,
  output logic               ExMemRead,
  output logic               ExBranch,
  output logic               ExJump,
  output logic               ExJumpReg,
  output logic               ExValid,
  output logic [ALUOP_W-1:0] ExALUOp,
  output logic [1:0]         ExRegDst,
  output logic [1:0]         ExMemToReg,
  output logic [1:0]         ExStoreType,
  output logic [1:0]         ExLoadType,
  output logic [4:0]         ExRt,
  output logic               Stall,
  output logic               Flush,
  output logic               IllegalInstr
);

  typedef enum logic {ST_RUN, ST_MULWAIT} state_e;

  localparam logic [3:0] MUL_BUSY_INIT = 4'(MUL_LATENCY - 1);

  state_e       state_q, state_d;
  logic [3:0]   busy_cnt_q, busy_cnt_d;
  ctrl_bundle_t id_ex_q, id_ex_d;
  logic [4:0]   ex_rt_q, ex_rt_d;
  logic         illegal_q, illegal_d;

  ctrl_bundle_t dec_ctrl;
  logic         dec_illegal;
  logic         dec_uses_rt;
  logic [4:0]   id_rs, id_rt;
  logic         load_use;
  logic         stall_c, flush_c;

  instr_decoder u_dec (
    .instr_i   (Instr),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .uses_rt_o (dec_uses_rt)
  );

  assign id_rs = Instr[25:21];
  assign id_rt = Instr[20:16];

  assign load_use = InstrValid & id_ex_q.valid & id_ex_q.mem_read & (ex_rt_q != '0) &
                    ((ex_rt_q == id_rs) | (dec_uses_rt & (ex_rt_q == id_rt)));

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    id_ex_d    = id_ex_q;
    ex_rt_d    = ex_rt_q;
    illegal_d  = 1'b0;
    stall_c    = 1'b0;
    flush_c    = 1'b0;
    if (Redirect) begin
      flush_c    = 1'b1;
      state_d    = ST_RUN;
      busy_cnt_d = '0;
      id_ex_d    = CTRL_BUBBLE;
      ex_rt_d    = '0;
    end else if (state_q == ST_MULWAIT) begin
      // MUL stays in EX; the count reaching zero releases the pipeline.
      stall_c    = 1'b1;
      busy_cnt_d = busy_cnt_q - 4'd1;
      if (busy_cnt_q == 4'd1) state_d = ST_RUN;
    end else if (load_use) begin
      stall_c = 1'b1;
      id_ex_d = CTRL_BUBBLE;
      ex_rt_d = '0;
    end else if (!InstrValid || dec_illegal) begin
      id_ex_d   = CTRL_BUBBLE;
      ex_rt_d   = '0;
      illegal_d = InstrValid & dec_illegal;
    end else begin
      id_ex_d = dec_ctrl;
      ex_rt_d = id_rt;
      if (dec_ctrl.alu_op == ALU_MUL && MUL_LATENCY > 1) begin
        busy_cnt_d = MUL_BUSY_INIT;
        state_d    = ST_MULWAIT;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_RUN;
      busy_cnt_q <= '0;
      id_ex_q    <= CTRL_BUBBLE;
      ex_rt_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      id_ex_q    <= id_ex_d;
      ex_rt_q    <= ex_rt_d;
      illegal_q  <= illegal_d;
    end
  end

  assign Stall        = Rst_n & stall_c;
  assign Flush        = Rst_n & flush_c;
  assign IllegalInstr = illegal_q;

  assign ExRegWrite  = id_ex_q.reg_write;
  assign ExALUSrc    = id_ex_q.alu_src;
  assign ExMemWrite  = id_ex_q.mem_write;
  assign ExMemRead   = id_ex_q.mem_read;
  assign ExBranch    = id_ex_q.branch;
  assign ExJump      = id_ex_q.jump;
  assign ExJumpReg   = id_ex_q.jump_reg;
  assign ExValid     = id_ex_q.valid;
  assign ExALUOp     = ALUOP_W'(id_ex_q.alu_op);
  assign ExRegDst    = id_ex_q.reg_dst;
  assign ExMemToReg  = id_ex_q.mem_to_reg;
  assign ExStoreType = id_ex_q.store_type;
  assign ExLoadType  = id_ex_q.load_type;
  assign ExRt        = ex_rt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench: a pipeline-level reference model predicts every cycle, a monitor compares.
module tb_pipeline_control_unit;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned LAT = 3;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] Instr = '0;
  logic        InstrValid = 1'b0;
  logic        Redirect = 1'b0;
  logic        ExRegWrite, ExALUSrc, ExMemWrite, ExMemRead, ExBranch, ExJump, ExJumpReg, ExValid;
  logic [3:0]  ExALUOp;
  logic [1:0]  ExRegDst, ExMemToReg, ExStoreType, ExLoadType;
  logic [4:0]  ExRt;
  logic        Stall, Flush, IllegalInstr;

  always #5 Clk = ~Clk;

  pipeline_control_unit #(.ALUOP_W(4), .MUL_LATENCY(LAT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .InstrValid(InstrValid), .Redirect(Redirect),
    .ExRegWrite(ExRegWrite), .ExALUSrc(ExALUSrc), .ExMemWrite(ExMemWrite), .ExMemRead(ExMemRead),
    .ExBranch(ExBranch), .ExJump(ExJump), .ExJumpReg(ExJumpReg), .ExValid(ExValid),
    .ExALUOp(ExALUOp), .ExRegDst(ExRegDst), .ExMemToReg(ExMemToReg), .ExStoreType(ExStoreType),
    .ExLoadType(ExLoadType), .ExRt(ExRt), .Stall(Stall), .Flush(Flush), .IllegalInstr(IllegalInstr)
  );

  typedef struct packed {
    logic       rw, src, mw, mr, br, j, jr, v;
    logic [3:0] alu;
    logic [1:0] dst, m2r, st, lt;
    logic [4:0] rt;
  } ref_t;

  typedef struct {
    ref_t ex;
    logic ill;
    logic stall;
    logic flush;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ref_t m_ex = '0;
  int   m_mul_left = 0;
  logic m_ill = 1'b0;
  logic last_stall = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Instruction-set reference: what each mnemonic needs from the datapath.
  function automatic ref_t ref_decode(input logic [31:0] ins, output bit legal,
                                      output bit reads_rt, output bit is_mul);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    logic [4:0] rt = ins[20:16];
    ref_t r = '0;
    legal = 1'b1; reads_rt = 1'b0; is_mul = 1'b0;
    r.v = 1'b1;
    if (op == 6'h00 && fn == 6'h08) r.jr = 1'b1;
    else if (op == 6'h00 || op == 6'h1C) begin
      r.rw = 1; r.dst = 2'd1; r.m2r = 2'd1; reads_rt = 1;
      r.alu = (op == 6'h1C) ? ALU_MUL : ALU_RTYPE;
      is_mul = (op == 6'h1C);
    end else if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
      r.rw = 1; r.src = 1; r.m2r = 2'd1;
      r.alu = (op == 6'h08) ? ALU_ADD : (op == 6'h0A) ? ALU_SLT :
              (op == 6'h0C) ? ALU_AND : (op == 6'h0D) ? ALU_OR : ALU_XOR;
    end else if (op == 6'h23 || op == 6'h21 || op == 6'h20) begin
      r.rw = 1; r.src = 1; r.mr = 1; r.alu = ALU_ADD;
      r.lt = (op == 6'h23) ? 2'd0 : (op == 6'h21) ? 2'd1 : 2'd2;
    end else if (op == 6'h2B || op == 6'h29 || op == 6'h28) begin
      r.mw = 1; r.src = 1; r.alu = ALU_ADD; reads_rt = 1;
      r.st = (op == 6'h2B) ? 2'd0 : (op == 6'h29) ? 2'd1 : 2'd2;
    end else if (op == 6'h04 || op == 6'h05) begin
      r.br = 1; r.alu = ALU_SUB; reads_rt = 1;
    end else if (op == 6'h06 || op == 6'h07 || (op == 6'h01 && rt <= 5'd1)) begin
      r.br = 1; r.alu = ALU_SUB;
    end else if (op == 6'h02) r.j = 1;
    else if (op == 6'h03) begin
      r.j = 1; r.rw = 1; r.dst = 2'd2; r.m2r = 2'd2;
    end else legal = 1'b0;
    if (!legal) r = '0;
    return r;
  endfunction

  task automatic step(input logic rst, input logic [31:0] ins, input logic v, input logic red);
    exp_t e;
    ref_t d;
    bit   legal, rrt, mul, lu;
    @(posedge Clk);
    #2;
    Rst_n = rst; Instr = ins; InstrValid = v; Redirect = red;
    if (!rst) begin
      e = '{ex: '0, ill: 1'b0, stall: 1'b0, flush: 1'b0};
      m_ex = '0; m_mul_left = 0; m_ill = 1'b0; last_stall = 1'b0;
    end else begin
      d  = ref_decode(ins, legal, rrt, mul);
      lu = v && m_ex.v && m_ex.mr && m_ex.rt != 0 &&
           (m_ex.rt == ins[25:21] || (rrt && m_ex.rt == ins[20:16]));
      e.ex = m_ex; e.ill = m_ill; e.flush = red;
      e.stall = !red && (m_mul_left > 0 || lu);
      last_stall = e.stall;
      m_ill = 1'b0;
      if (red) begin m_ex = '0; m_mul_left = 0; end
      else if (m_mul_left > 0) m_mul_left--;
      else if (lu || !v) m_ex = '0;
      else if (!legal) begin m_ex = '0; m_ill = 1'b1; end
      else begin
        m_ex = d; m_ex.rt = ins[20:16];
        if (mul) m_mul_left = LAT - 1;
      end
    end
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ins, input logic red = 1'b0);
    int guard = 0;
    step(1'b1, ins, 1'b1, red);
    while (last_stall && guard < 20) begin
      step(1'b1, ins, 1'b1, 1'b0);
      guard++;
    end
    if (guard >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL stall_bound: got %0d stall cycles expected < 20", guard);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] lo);
    return {op, rs, rt, lo};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[20] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h0A,
                            6'h0C, 6'h0D, 6'h0E, 6'h1C, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B};
    logic [5:0] fns[4] = '{6'h20, 6'h22, 6'h08, 6'h24};
    logic [5:0] op = ($urandom_range(9) == 0) ? 6'($urandom) : ops[$urandom_range(19)];
    logic [5:0] fn = ($urandom_range(4) == 0) ? 6'($urandom) : fns[$urandom_range(3)];
    return {op, 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom), 5'($urandom), fn};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #4;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ex_bundle", 32'({ExRegWrite, ExALUSrc, ExMemWrite, ExMemRead, ExBranch, ExJump,
                                ExJumpReg, ExValid, ExALUOp, ExRegDst, ExMemToReg, ExStoreType,
                                ExLoadType, ExRt}), 32'(e.ex));
        check("stall", 32'(Stall), 32'(e.stall));
        check("flush", 32'(Flush), 32'(e.flush));
        check("illegal", 32'(IllegalInstr), 32'(e.ill));
      end
    end
  end

  initial begin : driver
    logic [31:0] cur;
    logic        v, red, rst;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    issue(enc(OP_ADDI, 5'd1, 5'd2, 16'h0010));
    // load-use: LW $t0 then ADD $t1,$t0,$t2
    issue(enc(OP_LW, 5'd29, 5'd8, 16'h0004));
    issue(enc(OP_RTYPE, 5'd8, 5'd10, {5'd9, 5'd0, 6'h20}));
    step(1'b1, '0, 1'b0, 1'b0);
    // MUL then ORI
    issue(enc(OP_MUL, 5'd3, 5'd4, {5'd5, 5'd0, 6'h02}));
    issue(enc(OP_ORI, 5'd6, 5'd7, 16'h00ff));
    // redirect while a load-use hazard is present
    issue(enc(OP_LW, 5'd29, 5'd8, 16'h0000));
    issue(enc(OP_RTYPE, 5'd8, 5'd9, {5'd11, 5'd0, 6'h20}), 1'b1);
    issue(enc(OP_BEQ, 5'd1, 5'd2, 16'h0008));
    issue(enc(OP_ADDI, 5'd1, 5'd2, 16'h0001), 1'b1);
    // REGIMM and BGTZ
    issue(enc(OP_REGIMM, 5'd4, 5'd1, 16'h0010));
    issue(enc(OP_REGIMM, 5'd4, 5'd3, 16'h0010));
    issue(enc(OP_BGTZ, 5'd4, 5'd0, 16'h0010));
    step(1'b1, '0, 1'b0, 1'b0);
    // JAL, then LW $0 followed by a user of $0
    issue({OP_JAL, 26'h0001234});
    issue(enc(OP_LW, 5'd29, 5'd0, 16'h0000));
    issue(enc(OP_RTYPE, 5'd0, 5'd0, {5'd12, 5'd0, 6'h20}));
    // a bubble in IF/ID never stalls on a hazard
    issue(enc(OP_LW, 5'd29, 5'd8, 16'h0000));
    step(1'b1, enc(OP_RTYPE, 5'd8, 5'd8, {5'd9, 5'd0, 6'h20}), 1'b0, 1'b0);
    // reset while waiting on a MUL
    issue(enc(OP_MUL, 5'd3, 5'd4, {5'd5, 5'd0, 6'h02}));
    step(1'b1, enc(OP_ORI, 5'd6, 5'd7, 16'h0001), 1'b1, 1'b0);
    step(1'b0, enc(OP_ORI, 5'd6, 5'd7, 16'h0001), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    issue(enc(OP_ADDI, 5'd1, 5'd2, 16'h0020));
    issue(enc(OP_ADDI, 5'd2, 5'd3, 16'h0030));
    // randomized traffic with the fetch stage holding IF/ID under Stall
    cur = rand_instr();
    for (int i = 0; i < 2000; i++) begin
      v   = ($urandom_range(7) != 0);
      red = ($urandom_range(11) == 0);
      rst = ($urandom_range(249) != 0);
      step(rst, cur, v, red);
      if (!last_stall) cur = rand_instr();
    end
    step(1'b1, '0, 1'b0, 1'b0);
    repeat (3) @(posedge Clk);
    #6;
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
